// File: rtl/arb_sched_if.sv
// Host update bus, adjacency-matrix write port, engine handshakes and run result
// of the arbitrage run sequencer, bundled as one interface.
interface arb_sched_if #(
  parameter int IDX_W    = 4,
  parameter int WEIGHT_W = 32
);
  logic                       go;
  logic                       upd_valid;
  logic                       upd_ready;
  logic        [IDX_W-1:0]    upd_row;
  logic        [IDX_W-1:0]    upd_col;
  logic signed [WEIGHT_W-1:0] upd_weight;
  logic                       adjmat_we;
  logic        [IDX_W-1:0]    adjmat_wr_row;
  logic        [IDX_W-1:0]    adjmat_wr_col;
  logic signed [WEIGHT_W-1:0] adjmat_wr_data;
  logic                       init_start;
  logic                       init_done;
  logic                       relax_start;
  logic                       relax_done;
  logic                       relax_changed;
  logic                       cycle_reset;
  logic                       cycle_done;
  logic                       cycle_found;
  logic                       busy;
  logic                       result_valid;
  logic                       result_cycle;
  logic                       result_err;
  logic        [IDX_W-1:0]    pass_count;

  modport master (
    output go, upd_valid, upd_row, upd_col, upd_weight,
           init_done, relax_done, relax_changed, cycle_done, cycle_found,
    input  upd_ready, adjmat_we, adjmat_wr_row, adjmat_wr_col, adjmat_wr_data,
           init_start, relax_start, cycle_reset, busy,
           result_valid, result_cycle, result_err, pass_count
  );

  modport slave (
    input  go, upd_valid, upd_row, upd_col, upd_weight,
           init_done, relax_done, relax_changed, cycle_done, cycle_found,
    output upd_ready, adjmat_we, adjmat_wr_row, adjmat_wr_col, adjmat_wr_data,
           init_start, relax_start, cycle_reset, busy,
           result_valid, result_cycle, result_err, pass_count
  );
endinterface

// File: rtl/arb_sched.sv
// Bellman-Ford run sequencer: serialises host edge updates while idle, then drives
// init, up to NODES-1 relaxation passes and negative-cycle detection per go request.
module arb_sched #(
  parameter int NODES    = 16,
  parameter int IDX_W    = 4,
  parameter int WEIGHT_W = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  arb_sched_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WRITE, INIT, RELAX, DETECT, REPORT} state_t;

  localparam int               WD_W      = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NODES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t                     state, state_next;
  logic                       pending;
  logic                       init_start_q;
  logic                       relax_start_q;
  logic        [IDX_W-1:0]    pass_cnt;
  logic        [IDX_W-1:0]    pass_inc;
  logic        [WD_W-1:0]     wd;
  logic                       timeout;
  logic                       abort;
  logic                       relax_again;
  logic                       accept;
  logic                       res_cycle;
  logic                       res_err;
  logic        [IDX_W-1:0]    res_pass;
  logic        [IDX_W-1:0]    row_q;
  logic        [IDX_W-1:0]    col_q;
  logic signed [WEIGHT_W-1:0] weight_q;

  assign accept   = (state == IDLE) && bus.upd_valid;
  assign pass_inc = pass_cnt + IDX_W'(1);
  assign timeout  = (state inside {INIT, RELAX, DETECT}) && (wd == WD_LAST);

  // A done pulse wins over a watchdog expiry landing in the same cycle.
  always_comb begin
    state_next  = state;
    relax_again = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.upd_valid)            state_next = WRITE;
        else if (bus.go || pending)   state_next = INIT;
      end
      WRITE:  state_next = IDLE;
      INIT: begin
        if (bus.init_done)            state_next = RELAX;
        else if (timeout) begin
          state_next = REPORT;
          abort      = 1'b1;
        end
      end
      RELAX: begin
        if (bus.relax_done) begin
          if (!bus.relax_changed || (pass_inc == LAST_PASS)) state_next = DETECT;
          else                                               relax_again = 1'b1;
        end else if (timeout) begin
          state_next = REPORT;
          abort      = 1'b1;
        end
      end
      DETECT: begin
        if (bus.cycle_done)           state_next = REPORT;
        else if (timeout) begin
          state_next = REPORT;
          abort      = 1'b1;
        end
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      init_start_q  <= 1'b0;
      relax_start_q <= 1'b0;
      pass_cnt      <= '0;
      wd            <= '0;
      res_cycle     <= 1'b0;
      res_err       <= 1'b0;
      res_pass      <= '0;
    end else begin
      state         <= state_next;
      init_start_q  <= (state == IDLE) && (state_next == INIT);
      relax_start_q <= ((state == INIT) && (state_next == RELAX)) || relax_again;

      // Every go before a run starts is absorbed by it; at most one rerun queues.
      if ((state == IDLE) && (state_next == INIT))      pending <= 1'b0;
      else if (bus.go && ((state != IDLE) || accept))   pending <= 1'b1;

      if (((state == IDLE) && (state_next == INIT)) ||
          ((state == INIT) && (state_next == RELAX)))    pass_cnt <= '0;
      else if ((state == RELAX) && bus.relax_done)      pass_cnt <= pass_inc;

      if ((state_next != state) || relax_again)         wd <= '0;
      else if (state inside {INIT, RELAX, DETECT})      wd <= wd + WD_W'(1);

      if ((state != REPORT) && (state_next == REPORT)) begin
        res_err   <= abort;
        res_cycle <= !abort && bus.cycle_found;
        res_pass  <= pass_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      row_q    <= bus.upd_row;
      col_q    <= bus.upd_col;
      weight_q <= bus.upd_weight;
    end
  end

  assign bus.upd_ready      = (state == IDLE);
  assign bus.adjmat_we      = (state == WRITE);
  assign bus.adjmat_wr_row  = (state == WRITE) ? row_q    : '0;
  assign bus.adjmat_wr_col  = (state == WRITE) ? col_q    : '0;
  assign bus.adjmat_wr_data = (state == WRITE) ? weight_q : '0;
  assign bus.init_start     = init_start_q;
  assign bus.relax_start    = relax_start_q;
  assign bus.cycle_reset    = (state != DETECT);
  assign bus.busy           = (state inside {INIT, RELAX, DETECT, REPORT});
  assign bus.result_valid   = (state == REPORT);
  assign bus.result_cycle   = res_cycle;
  assign bus.result_err     = res_err;
  assign bus.pass_count     = res_pass;

endmodule

// File: tb/tb_arb_sched.sv
// Directed bench for arb_sched: the bench plays host and engine models step by step
// and checks each output against hand-computed values.
module tb_arb_sched;

  localparam int NODES    = 16;
  localparam int IDX_W    = 4;
  localparam int WEIGHT_W = 32;
  localparam int TIMEOUT  = 4096;

  localparam int S_INIT_START  = 0;
  localparam int S_RELAX_START = 1;
  localparam int S_RESULT      = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   is_cnt = 0;
  int   rs_cnt = 0;

  arb_sched_if #(.IDX_W(IDX_W), .WEIGHT_W(WEIGHT_W)) bus ();

  arb_sched #(.NODES(NODES), .IDX_W(IDX_W), .WEIGHT_W(WEIGHT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.init_start)  is_cnt <= is_cnt + 1;
    if (bus.relax_start) rs_cnt <= rs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      S_INIT_START:  return bus.init_start;
      S_RELAX_START: return bus.relax_start;
      S_RESULT:      return bus.result_valid;
      default:       return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag, input int budget, output int n);
    n = 0;
    while (!sig(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sig(which) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=timeout_after_%0d expected=asserted", tag, n);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Init handshake, npass relaxation passes (last one reports last_changed), then detection.
  task automatic run_engines(input int npass, input logic last_changed, input logic found);
    int n;
    wait_sig(S_INIT_START, "init_start", 10, n);
    bus.init_done = 1'b1;
    tick();
    bus.init_done = 1'b0;
    for (int p = 1; p <= npass; p++) begin
      chk($sformatf("relax_start_p%0d", p), 32'(bus.relax_start), 32'(1));
      bus.relax_done    = 1'b1;
      bus.relax_changed = (p < npass) ? 1'b1 : last_changed;
      tick();
      bus.relax_done    = 1'b0;
      bus.relax_changed = 1'b0;
    end
    chk("detect_cycle_reset_low", 32'(bus.cycle_reset), 32'(0));
    tick();
    bus.cycle_done  = 1'b1;
    bus.cycle_found = found;
    tick();
    bus.cycle_done  = 1'b0;
    bus.cycle_found = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    bus.go = 1'b0; bus.upd_valid = 1'b0; bus.upd_row = '0; bus.upd_col = '0;
    bus.upd_weight = '0; bus.init_done = 1'b0; bus.relax_done = 1'b0;
    bus.relax_changed = 1'b0; bus.cycle_done = 1'b0; bus.cycle_found = 1'b0;

    repeat (3) tick();
    chk("rst_cycle_reset", 32'(bus.cycle_reset), 32'(1));
    chk("rst_upd_ready",   32'(bus.upd_ready),   32'(1));
    chk("rst_busy",        32'(bus.busy),        32'(0));
    chk("rst_result",      32'({bus.result_valid, bus.result_cycle, bus.result_err}), 32'(0));
    chk("rst_pass_count",  32'(bus.pass_count),  32'(0));
    chk("rst_we",          32'(bus.adjmat_we),   32'(0));
    reset_n = 1'b1;
    tick();
    chk("idle_upd_ready",  32'(bus.upd_ready),   32'(1));

    // Single update write
    bus.upd_valid = 1'b1; bus.upd_row = 4'd2; bus.upd_col = 4'd5; bus.upd_weight = -32'sd7;
    tick();
    bus.upd_valid = 1'b0;
    chk("wr_we",        32'(bus.adjmat_we),      32'(1));
    chk("wr_row",       32'(bus.adjmat_wr_row),  32'(2));
    chk("wr_col",       32'(bus.adjmat_wr_col),  32'(5));
    chk("wr_data",      bus.adjmat_wr_data,      32'hFFFF_FFF9);
    chk("wr_upd_ready", 32'(bus.upd_ready),      32'(0));
    tick();
    chk("wr_we_off",    32'(bus.adjmat_we),      32'(0));
    chk("wr_ready_back", 32'(bus.upd_ready),     32'(1));

    // Full run: every pass changes, cycle found
    base = rs_cnt;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("go_init_start", 32'(bus.init_start), 32'(1));
    chk("run_busy",      32'(bus.busy),       32'(1));
    run_engines(15, 1'b1, 1'b1);
    chk("full_result_valid", 32'(bus.result_valid), 32'(1));
    chk("full_result_cycle", 32'(bus.result_cycle), 32'(1));
    chk("full_result_err",   32'(bus.result_err),   32'(0));
    chk("full_pass_count",   32'(bus.pass_count),   32'(15));
    chk("full_relax_starts", 32'(rs_cnt - base),    32'(15));
    tick();
    chk("full_pulse_end",  32'(bus.result_valid), 32'(0));
    chk("full_idle_busy",  32'(bus.busy),         32'(0));
    chk("full_pass_held",  32'(bus.pass_count),   32'(15));
    chk("full_cycle_held", 32'(bus.result_cycle), 32'(1));

    // Early exit on third pass
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    run_engines(3, 1'b0, 1'b0);
    chk("early_result_valid", 32'(bus.result_valid), 32'(1));
    chk("early_pass_count",   32'(bus.pass_count),   32'(3));
    chk("early_result_cycle", 32'(bus.result_cycle), 32'(0));
    tick();

    // go together with an update: write first, run on next idle cycle
    bus.go = 1'b1; bus.upd_valid = 1'b1;
    bus.upd_row = 4'd7; bus.upd_col = 4'd1; bus.upd_weight = 32'sd100;
    tick();
    bus.go = 1'b0; bus.upd_valid = 1'b0;
    chk("both_we",         32'(bus.adjmat_we),      32'(1));
    chk("both_data",       bus.adjmat_wr_data,      32'd100);
    chk("both_no_start",   32'(bus.init_start),     32'(0));
    tick();
    chk("both_idle_ready", 32'(bus.upd_ready),      32'(1));
    chk("both_idle_start", 32'(bus.init_start),     32'(0));
    tick();
    chk("both_run_start",  32'(bus.init_start),     32'(1));
    run_engines(1, 1'b0, 1'b0);
    chk("both_pass_count", 32'(bus.pass_count),     32'(1));
    tick();

    // go twice during RELAX queues exactly one rerun
    base = is_cnt;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_sig(S_INIT_START, "rerun_init_start", 10, n);
    bus.init_done = 1'b1;
    tick();
    bus.init_done = 1'b0;
    bus.relax_done = 1'b1; bus.relax_changed = 1'b1; bus.go = 1'b1;
    tick();
    bus.relax_done = 1'b0; bus.relax_changed = 1'b0; bus.go = 1'b0;
    chk("rerun_relax2", 32'(bus.relax_start), 32'(1));
    bus.relax_done = 1'b1; bus.relax_changed = 1'b0; bus.go = 1'b1;
    tick();
    bus.relax_done = 1'b0; bus.go = 1'b0;
    chk("rerun_detect", 32'(bus.cycle_reset), 32'(0));
    bus.cycle_done = 1'b1;
    tick();
    bus.cycle_done = 1'b0;
    chk("rerun_first_result", 32'(bus.result_valid), 32'(1));
    chk("rerun_first_pass",   32'(bus.pass_count),   32'(2));
    tick();
    chk("rerun_idle", 32'(bus.busy), 32'(0));
    tick();
    chk("rerun_second_start", 32'(bus.init_start), 32'(1));
    run_engines(1, 1'b0, 1'b1);
    chk("rerun_second_cycle", 32'(bus.result_cycle), 32'(1));
    repeat (10) tick();
    chk("rerun_run_count", 32'(is_cnt - base), 32'(2));
    chk("rerun_settled",   32'(bus.busy),      32'(0));

    // init_done never arrives: watchdog abort
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("to_init_start", 32'(bus.init_start), 32'(1));
    wait_sig(S_RESULT, "to_result_valid", TIMEOUT + 100, n);
    checks++;
    assert (n >= TIMEOUT && n <= TIMEOUT + 2) else begin
      errors++;
      $error("FAIL to_latency observed=%0d expected=%0d..%0d", n, TIMEOUT, TIMEOUT + 2);
    end
    chk("to_result_err",   32'(bus.result_err),   32'(1));
    chk("to_result_cycle", 32'(bus.result_cycle), 32'(0));
    chk("to_pass_count",   32'(bus.pass_count),   32'(0));
    chk("to_cycle_reset",  32'(bus.cycle_reset),  32'(1));
    tick();
    chk("to_idle_busy",    32'(bus.busy),         32'(0));
    chk("to_idle_ready",   32'(bus.upd_ready),    32'(1));

    // Asynchronous reset during DETECT
    base = is_cnt;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    wait_sig(S_INIT_START, "ar_init_start", 10, n);
    bus.init_done = 1'b1;
    tick();
    bus.init_done = 1'b0;
    bus.relax_done = 1'b1; bus.relax_changed = 1'b0;
    tick();
    bus.relax_done = 1'b0; bus.go = 1'b1;
    chk("ar_in_detect", 32'(bus.cycle_reset), 32'(0));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_cycle_reset", 32'(bus.cycle_reset), 32'(1));
    chk("ar_busy",        32'(bus.busy),        32'(0));
    chk("ar_upd_ready",   32'(bus.upd_ready),   32'(1));
    chk("ar_result_err",  32'(bus.result_err),  32'(0));
    bus.go = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("ar_no_result",   32'(bus.result_valid), 32'(0));
    chk("ar_no_rerun",    32'(is_cnt - base),    32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
